reaction_timer_controller: RTL and testbench

//   Top-level sequencer for the reaction-timer game.
//   - Start press: pulses sample_o so random_delay_generator captures a delay.
//   - Waits MIN_WAIT_MS plus the sampled random ms, lights the stimulus LED,

---
 rtl/reaction_timer_pkg.sv | 19 +
 rtl/reaction_timer_controller_ms_tick.sv | 32 +++
 rtl/reaction_timer_controller.sv | 128 ++++++++++++
 tb/tb_reaction_timer_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and default constants for the reaction-timer game controller.
package reaction_timer_pkg;

    localparam int MS_W            = 14;
    localparam int WAIT_W          = 16;
    localparam int DEF_TICK_CYCLES = 50_000;
    localparam int DEF_MIN_WAIT_MS = 2000;
    localparam int DEF_MAX_MS      = 9999;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        TIMING,
        DONE,
        EARLY
    } state_t;

endpackage

// File: rtl/reaction_timer_controller_ms_tick.sv
// Millisecond prescaler: counts TICK_CYCLES clocks while enabled and pulses
// tick_o on the last count, wrapping back to zero.
module ms_tick_generator #(
    parameter int TICK_CYCLES = 50_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_o = en_i && !clear_i && (cnt == LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (clear_i || !en_i) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_timer_controller.sv
// Reaction-timer sequencer: arms a random delay, lights the stimulus LED and
// measures the player's reaction in milliseconds, flagging cheats and timeouts.
module reaction_timer_controller
    import reaction_timer_pkg::*;
#(
    parameter int COUNT_N     = 30,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int MIN_WAIT_MS = DEF_MIN_WAIT_MS,
    parameter int RAND_BITS   = 11,
    parameter int MAX_MS      = DEF_MAX_MS
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clear_i,
    input  logic [COUNT_N-1:0] random_delay_i,
    output logic               sample_o,
    output logic               led_o,
    output logic               busy_o,
    output logic [MS_W-1:0]    reaction_ms_o,
    output logic               done_o,
    output logic               early_o,
    output logic               timeout_o
);

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MAX_MS - 1);
    localparam logic [MS_W-1:0] MS_MAX  = MS_W'(MAX_MS);

    state_t              state;
    logic [WAIT_W-1:0]   wait_ms;
    logic [WAIT_W-1:0]   wait_load;
    logic [MS_W-1:0]     ms_cnt;
    logic [MS_W-1:0]     reaction_ms;
    logic                timeout;
    logic                counting;
    logic                tick;
    logic                unused_rand_bits;

    assign unused_rand_bits = ^random_delay_i[COUNT_N-1:RAND_BITS];
    assign wait_load = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(random_delay_i[RAND_BITS-1:0]);

    // ARM keeps the prescaler at zero so WAIT always starts on a full millisecond.
    assign counting = (state == WAIT) || (state == TIMING);

    ms_tick_generator #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_ms_tick (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(!counting),
        .en_i   (counting),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            wait_ms     <= '0;
            ms_cnt      <= '0;
            reaction_ms <= '0;
            timeout     <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            wait_ms     <= '0;
            ms_cnt      <= '0;
            reaction_ms <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= ARM;
                        reaction_ms <= '0;
                        timeout     <= 1'b0;
                    end
                end
                ARM: begin
                    wait_ms <= wait_load;
                    ms_cnt  <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (stop_i) begin
                        state <= EARLY;
                    end else if (tick) begin
                        wait_ms <= wait_ms - WAIT_W'(1);
                        if (wait_ms == WAIT_W'(1)) begin
                            state  <= TIMING;
                            ms_cnt <= '0;
                        end
                    end
                end
                TIMING: begin
                    // A stop coinciding with a tick reports the pre-tick count.
                    if (stop_i) begin
                        state       <= DONE;
                        reaction_ms <= ms_cnt;
                    end else if (tick) begin
                        if (ms_cnt == MS_LAST) begin
                            state       <= DONE;
                            reaction_ms <= MS_MAX;
                            timeout     <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end
                end
                EARLY: begin
                    state <= EARLY;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sample_o      = !reset_i && !clear_i && start_i &&
                           ((state == IDLE) || (state == DONE));
    assign led_o         = (state == TIMING);
    assign busy_o        = (state == ARM) || (state == WAIT) || (state == TIMING);
    assign done_o        = (state == DONE);
    assign early_o       = (state == EARLY);
    assign timeout_o     = timeout;
    assign reaction_ms_o = reaction_ms;

endmodule

// File: tb/tb_reaction_timer_controller.sv
// Bench for reaction_timer_controller: directed rounds plus random traffic,
// checked every cycle against a timestamp-based model of a game round.
module tb_reaction_timer_controller;

    localparam int COUNT_N   = 30;
    localparam int TICK      = 10;
    localparam int MIN_WAIT  = 4;
    localparam int RAND_BITS = 2;
    localparam int MAX_MS    = 20;

    localparam int P_IDLE   = 0;
    localparam int P_ARM    = 1;
    localparam int P_WAIT   = 2;
    localparam int P_TIMING = 3;
    localparam int P_DONE   = 4;
    localparam int P_EARLY  = 5;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic               clear_i = 1'b0;
    logic [COUNT_N-1:0] random_delay_i = '0;
    logic               sample_o;
    logic               led_o;
    logic               busy_o;
    logic [13:0]        reaction_ms_o;
    logic               done_o;
    logic               early_o;
    logic               timeout_o;
    logic [19:0]        outs;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Round model: phase plus the absolute cycles where WAIT and TIMING begin.
    int          m_phase = P_IDLE;
    int          t_wait = 0;
    int          t_led = 0;
    logic [13:0] m_ms = '0;
    logic        m_to = 1'b0;

    reaction_timer_controller #(
        .COUNT_N    (COUNT_N),
        .TICK_CYCLES(TICK),
        .MIN_WAIT_MS(MIN_WAIT),
        .RAND_BITS  (RAND_BITS),
        .MAX_MS     (MAX_MS)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .clear_i       (clear_i),
        .random_delay_i(random_delay_i),
        .sample_o      (sample_o),
        .led_o         (led_o),
        .busy_o        (busy_o),
        .reaction_ms_o (reaction_ms_o),
        .done_o        (done_o),
        .early_o       (early_o),
        .timeout_o     (timeout_o)
    );

    assign outs = {sample_o, led_o, busy_o, done_o, early_o, timeout_o, reaction_ms_o};

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] exp_outs(input logic s, input logic c);
        logic smp;
        logic bsy;
        smp = ((m_phase == P_IDLE) || (m_phase == P_DONE)) && s && !c;
        bsy = (m_phase == P_ARM) || (m_phase == P_WAIT) || (m_phase == P_TIMING);
        return {smp, m_phase == P_TIMING, bsy, m_phase == P_DONE,
                m_phase == P_EARLY, m_to, m_ms};
    endfunction

    task automatic model_update(input logic s, input logic p, input logic c,
                                input logic [COUNT_N-1:0] r);
        if (c) begin
            m_phase = P_IDLE;
            m_ms    = '0;
            m_to    = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (s) begin
                    m_phase = P_ARM;
                    m_ms    = '0;
                    m_to    = 1'b0;
                end
                P_ARM: begin
                    t_wait  = cyc + 1;
                    t_led   = t_wait + (MIN_WAIT + int'(r % (1 << RAND_BITS))) * TICK;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (p) m_phase = P_EARLY;
                    else if (cyc + 1 == t_led) m_phase = P_TIMING;
                end
                P_TIMING: begin
                    if (p) begin
                        m_phase = P_DONE;
                        m_ms    = 14'((cyc - t_led) / TICK);
                    end else if (cyc + 1 == t_led + MAX_MS * TICK) begin
                        m_phase = P_DONE;
                        m_ms    = 14'(MAX_MS);
                        m_to    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c,
                        input logic [COUNT_N-1:0] r);
        @(negedge clk_i);
        start_i        = s;
        stop_i         = p;
        clear_i        = c;
        random_delay_i = r;
        #1;
        check($sformatf("outs@%0d", cyc), {12'b0, outs}, {12'b0, exp_outs(s, c)});
        @(posedge clk_i);
        model_update(s, p, c, r);
        cyc++;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, COUNT_N'($urandom));
    endtask

    task automatic go_to(input int target);
        int n = 0;
        while (cyc < target && n < 10000) begin
            idle_step();
            n++;
        end
        check($sformatf("goto_%0d", target), 32'(cyc), 32'(target));
    endtask

    task automatic start_round(input logic [COUNT_N-1:0] r);
        step(1'b1, 1'b0, 1'b0, COUNT_N'($urandom));
        step(1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset(input logic with_start);
        @(negedge clk_i);
        start_i = with_start;
        stop_i  = 1'b0;
        clear_i = 1'b0;
        reset_i = 1'b1;
        #1;
        check("reset_outs", {12'b0, outs}, 32'd0);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        start_i = 1'b0;
        m_phase = P_IDLE;
        m_ms    = '0;
        m_to    = 1'b0;
        cyc++;
    endtask

    initial begin
        do_reset(1'b0);

        // Normal round: delay 3 -> 7 ms wait, stop 5 ms into TIMING.
        start_round(COUNT_N'(3));
        #1 check("s1_busy", 32'(busy_o), 32'd1);
        go_to(t_led);
        #1 check("s1_led", 32'(led_o), 32'd1);
        go_to(t_led + 50);
        step(1'b0, 1'b1, 1'b0, '0);
        #1;
        check("s1_done", 32'(done_o), 32'd1);
        check("s1_ms", 32'(reaction_ms_o), 32'd5);
        check("s1_led_off", 32'(led_o), 32'd0);

        // Early press 2 ms into WAIT; start is then ignored until clear.
        step(1'b0, 1'b0, 1'b1, '0);
        start_round('0);
        go_to(t_wait + 20);
        step(1'b0, 1'b1, 1'b0, '0);
        #1 check("s2_early", 32'(early_o), 32'd1);
        step(1'b1, 1'b0, 1'b0, '0);
        #1 check("s2_start_ignored", 32'(early_o), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0);
        #1 check("s2_cleared", 32'(early_o), 32'd0);

        // Timeout after MAX_MS in TIMING.
        start_round(COUNT_N'($urandom));
        go_to(t_led + MAX_MS * TICK);
        #1;
        check("s3_done", 32'(done_o), 32'd1);
        check("s3_timeout", 32'(timeout_o), 32'd1);
        check("s3_ms", 32'(reaction_ms_o), 32'd20);

        // Stop on the final WAIT tick counts as early.
        start_round(COUNT_N'($urandom));
        go_to(t_led - 1);
        step(1'b0, 1'b1, 1'b0, '0);
        #1 check("s4_final_tick_early", 32'(early_o), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0);

        // Stop on the first TIMING cycle, then coincident with the tick at count 6.
        start_round(COUNT_N'($urandom));
        go_to(t_led);
        step(1'b0, 1'b1, 1'b0, '0);
        #1 check("s4_zero_ms", 32'(reaction_ms_o), 32'd0);
        start_round(COUNT_N'($urandom));
        go_to(t_led + 69);
        step(1'b0, 1'b1, 1'b0, '0);
        #1 check("s4_tick_stop", 32'(reaction_ms_o), 32'd6);

        // Clear beats stop in TIMING; async reset mid-WAIT.
        start_round(COUNT_N'($urandom));
        go_to(t_led + 30);
        step(1'b0, 1'b1, 1'b1, '0);
        #1 check("s5_clear_stop", {12'b0, outs}, 32'd0);
        start_round(COUNT_N'($urandom));
        go_to(t_wait + 15);
        do_reset(1'b1);

        // Back-to-back rounds: start from DONE, second delay 1 -> 5 ms wait.
        start_round(COUNT_N'($urandom));
        go_to(t_led + 33);
        step(1'b0, 1'b1, 1'b0, '0);
        #1 check("s6_first_ms", 32'(reaction_ms_o), 32'd3);
        step(1'b1, 1'b0, 1'b0, '0);
        #1 check("s6_flags_cleared", {28'b0, done_o, timeout_o, |reaction_ms_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, COUNT_N'(1));
        go_to(t_wait + 49);
        #1 check("s6_led_before", 32'(led_o), 32'd0);
        idle_step();
        #1 check("s6_led_at_5ms", 32'(led_o), 32'd1);

        // Random traffic: start and stop never together, clear anywhere.
        for (int i = 0; i < 6000; i++) begin
            int unsigned x;
            logic s, p, c;
            x = $urandom_range(0, 999);
            s = (x < 40);
            p = (x >= 40) && (x < 55);
            c = ($urandom_range(0, 299) == 0);
            step(s, p, c, COUNT_N'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
